// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone B4 pipelined initiator, one command per bus cycle with bounded retry.
// Define WB_MASTER_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT cycles with status 11.
module wb_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RTY_MAX    = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic [1:0]              rsp_status_o,
   output logic                    busy_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   input  logic                    wb_stall_i
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t     state, state_nxt;
   logic [3:0] rty_cnt;
   logic [1:0] status_nxt;
   logic       rty_inc, cap_dat, accept, tmo_hit;

   // Bus and handshake outputs decode straight from the state register, so
   // an asynchronous reset drops cyc/stb at once.
   assign accept      = state == IDLE && cmd_valid_i;
   assign cmd_ready_o = state == IDLE && rst_n_i;
   assign busy_o      = state != IDLE;
   assign wb_cyc_o    = state == REQ || state == WAIT;
   assign wb_stb_o    = state == REQ;
   assign rsp_valid_o = state == RESP;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
   assign tmo_hit = wb_cyc_o && tmo_cnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) tmo_cnt <= '0;
      else if (accept) tmo_cnt <= '0;
      else if (wb_cyc_o) tmo_cnt <= tmo_cnt + 1'b1;
`else
   // no counter: TIMEOUT is only referenced here and never fires
   assign tmo_hit = TIMEOUT < 0;
`endif

   always_comb begin
      state_nxt  = state;
      status_nxt = rsp_status_o;
      rty_inc    = 1'b0;
      cap_dat    = 1'b0;
      case (state)
         IDLE: if (cmd_valid_i) begin
            state_nxt  = REQ;
            status_nxt = 2'b00;
         end
         REQ: if (tmo_hit) begin
            state_nxt  = RESP;
            status_nxt = 2'b11;
         end else if (!wb_stall_i) state_nxt = WAIT;
         WAIT: if (tmo_hit) begin
            state_nxt  = RESP;
            status_nxt = 2'b11;
         end else if (wb_err_i) begin
            state_nxt  = RESP;
            status_nxt = 2'b01;
         end else if (wb_rty_i) begin
            if (rty_cnt < 4'(RTY_MAX)) begin
               state_nxt = REQ;
               rty_inc   = 1'b1;
            end else begin
               state_nxt  = RESP;
               status_nxt = 2'b10;
            end
         end else if (wb_ack_i) begin
            state_nxt  = RESP;
            status_nxt = 2'b00;
            cap_dat    = !wb_we_o;
         end
         default: if (rsp_ready_i) state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state        <= IDLE;
         rty_cnt      <= '0;
         rsp_status_o <= '0;
         rsp_dat_o    <= '0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_sel_o     <= '0;
         wb_dat_o     <= '0;
      end else begin
         state        <= state_nxt;
         rsp_status_o <= status_nxt;
         if (accept) begin
            wb_we_o   <= cmd_we_i;
            wb_adr_o  <= cmd_adr_i;
            wb_sel_o  <= cmd_sel_i;
            wb_dat_o  <= cmd_dat_i;
            rsp_dat_o <= '0;
            rty_cnt   <= '0;
         end else begin
            if (rty_inc) rty_cnt <= rty_cnt + 1'b1;
            if (cap_dat) rsp_dat_o <= wb_dat_i;
         end
      end
endmodule
